// File: rtl/tinyalu_pkg.sv
// Shared types for the tiny ALU.
// op_e    : 3-bit operation code presented on the op port.
// state_e : sequencing FSM states; the top exposes the current state on a debug port.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_SUB = 3'b101,
    OP_CMP = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/tinyalu_param_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset (clears all state)
//   load          : capture a (multiplicand) and b (multiplier), clear the high half
//   a, b          : WIDTH-bit unsigned operands
//   step_en       : perform one shift-add step at this edge
//   product       : 2*WIDTH-bit value the accumulator holds after this cycle's
//                   step (combinational look-ahead while step_en is high), so
//                   the owner can capture the final product on the last step edge
// The owner counts steps; after WIDTH steps product is the full a*b.
module tinyalu_param_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step_en,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand;
  // acc = {partial high half, remaining multiplier bits}; the multiplier is
  // consumed from bit 0 while the product grows in from the top.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     hi_sum;

  always_comb begin
    hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_step = {hi_sum, acc[WIDTH-1:1]};
    product  = step_en ? acc_step : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (step_en) begin
      acc   <= acc_step;
    end
  end

endmodule

// File: rtl/tinyalu_param.sv
// Tiny multi-cycle ALU: single-cycle ADD/AND/XOR/SUB/CMP, WIDTH-cycle MUL.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   A, B          : WIDTH-bit unsigned operands
//   op            : operation code (tinyalu_pkg::op_e encoding)
//   start         : request to start an operation
//   done          : one-cycle pulse, result/err valid
//   result        : 2*WIDTH-bit result, held until the next done
//   busy          : high whenever the FSM is not in IDLE
//   err           : illegal-op flag, updated with done
//   state_dbg     : current FSM state for observation
//
// Handshake: start is a request with no ready; it is sampled only while the
// FSM is IDLE (busy=0) and op!=NOP, and the operands/op are consumed at that
// same edge. Any start seen while busy=1 (including the DONE cycle) is dropped.
module tinyalu_param
  import tinyalu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               err,
  output state_e             state_dbg
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e             state;
  logic [CW-1:0]      step_cnt;
  op_e                op_in;
  logic               accept;
  logic               mul_load;
  logic               mul_step;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [2*WIDTH-1:0] alu_res;
  logic [2*WIDTH-1:0] mul_product;

  assign op_in     = op_e'(op);
  assign accept    = (state == ST_IDLE) && start && (op_in != OP_NOP);
  assign mul_load  = accept && (op_in == OP_MUL);
  assign mul_step  = (state == ST_MUL);
  assign state_dbg = state;

  // Single-cycle results computed straight from the inputs at the accept edge.
  always_comb begin
    sum_w   = {1'b0, A} + {1'b0, B};
    diff_w  = {1'b0, A} - {1'b0, B};
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, sum_w};
      OP_AND:  alu_res = {{WIDTH{1'b0}}, A & B};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, A ^ B};
      // (WIDTH+1)-bit difference, sign bit replicated up to 2*WIDTH
      OP_SUB:  alu_res = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
      OP_CMP:  alu_res = {{(2*WIDTH-2){1'b0}}, (A > B), (A == B)};
      default: alu_res = '0;
    endcase
  end

  tinyalu_param_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .a       (A),
    .b       (B),
    .step_en (mul_step),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            step_cnt <= '0;
            if (op_in == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= alu_res;
              err    <= (op_in == OP_ILL);
            end
          end
        end
        ST_MUL: begin
          step_cnt <= step_cnt + CW'(1);
          // mul_product already includes the step taken at this edge
          if (step_cnt == LAST_STEP) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= mul_product;
            err    <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tinyalu_param.md
TINYALU_PARAM -- requirements
Module: tinyalu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on posedge clk.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port A, input, WIDTH bits: operand A, unsigned.
REQ-005 SHALL have port B, input, WIDTH bits: operand B, unsigned.
REQ-006 SHALL have port op, input, 3 bits: operation code of type op_e.
REQ-007 SHALL have port start, input, 1 bit: request to start an operation.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-009 SHALL have port result, output, 2*WIDTH bits: operation result.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port err, output, 1 bit: illegal-op flag, valid with done.

Function
REQ-012 SHALL decode op as: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110 CMP, 111 illegal.
REQ-013 SHALL have FSM states IDLE, MUL and DONE, with done=1 only in DONE.
REQ-014 SHALL accept an operation only in IDLE at a posedge with start=1 and op!=NOP ("cycle 0"), latching A, B and op at that edge.
REQ-015 SHALL ignore start while busy=1, and SHALL ignore changes to A, B and op after acceptance.
REQ-016 SHALL treat start with op=NOP as a no-op: FSM stays IDLE, no done, result unchanged.
REQ-017 SHALL, for ADD, AND, XOR, SUB, CMP and illegal ops, transition IDLE->DONE, with done=1 at cycle 1 and IDLE at cycle 2.
REQ-018 SHALL, for MUL, transition IDLE->MUL, perform one shift-add step per cycle for cycles 1..WIDTH, then enter DONE at cycle WIDTH+1.
REQ-019 SHALL implement ADD as the zero-extended sum, with the carry in bit WIDTH.
REQ-020 SHALL implement AND and XOR as bitwise operations, zero-extended.
REQ-021 SHALL implement SUB as the (WIDTH+1)-bit two's-complement result of A-B, sign-extended to 2*WIDTH.
REQ-022 SHALL implement CMP as result[1:0] = {A>B, A==B} unsigned, with upper bits 0.
REQ-023 SHALL implement MUL as the full unsigned 2*WIDTH-bit product; 0*x and x*0 still take the full latency.
REQ-024 SHALL, for op=111, set err=1 and result=0; all other ops set err=0.
REQ-025 SHALL update result and err only on entry to DONE, holding both until the next DONE.
REQ-026 SHALL make the maximum throughput one single-cycle op per 2 cycles and one MUL per WIDTH+2 cycles.
REQ-027 SHALL ignore start asserted in the DONE cycle; it is accepted at the following edge only if still high.

Reset
REQ-028 SHALL, while reset=1, immediately force state=IDLE, done=0, busy=0, err=0, result=0, and clear the multiplier counter and accumulator.
REQ-029 SHALL abort any in-flight operation on reset assertion, producing no done after release.
REQ-030 SHALL make the first acceptance possible at the first posedge after reset deasserts.

Structure
REQ-031 SHALL define op_e and the FSM state typedef in shared package tinyalu_pkg.
REQ-032 SHALL place the iterative shift-add multiplier in sub-module tinyalu_param_mul, with ports clk, reset, load, a, b, step_en, product; the top FSM owns the sequencing.

Verification
REQ-033 WIDTH=8, ADD A=8'hFF B=8'h01 -> done at cycle 1, result=16'h0100, err=0, busy=1 only in cycle 1.
REQ-034 WIDTH=8, MUL A=8'hFF B=8'hFF -> busy in cycles 1..9, done at cycle 9, result=16'hFE01; a start pulse with ADD at cycle 4 is ignored.
REQ-035 WIDTH=8, SUB A=8'h03 B=8'h05 -> result=16'hFFFE; CMP A=8'h07 B=8'h07 -> result=16'h0001.
REQ-036 WIDTH=8, MUL in progress, reset pulsed at cycle 4 -> busy=0 and result=0 immediately, no done in the next 20 cycles.
REQ-037 op=3'b111 with A=8'h12 -> done at cycle 1, err=1, result=0; a following NOP start -> no done, err and result held.
REQ-038 WIDTH=16, MUL A=16'hFFFF B=16'h0002 -> done at cycle 17, result=32'h0001FFFE.
